frame_reader: RTL and testbench
===============================

FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 SHALL have parameters: IMG_W, default 128, pixels per row; IMG_H, default 63, rows per frame; ADDR_W, default 13, result-memory address width.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  in  1  one-cycle pulse requesting readout of one frame (driven by interpolator done edge).
REQ-005 SHALL have port mem_rd  out  1  result-memory read strobe.
REQ-006 SHALL have port mem_addr  out  ADDR_W  result-memory read address.
REQ-007 SHALL have port mem_data  in  8  read data, valid the cycle after mem_rd.
REQ-008 SHALL have port out_valid  out  1  output pixel valid.
REQ-009 SHALL have port out_ready  in  1  downstream accept.
REQ-010 SHALL have port out_data  out  8  pixel value.
REQ-011 SHALL have port out_sof  out  1  qualifies the first pixel of the frame (address 0).
REQ-012 SHALL have port out_eol  out  1  qualifies the last pixel of each row (column IMG_W-1).
REQ-013 SHALL have port busy  out  1  high from accepted start until the last pixel handshake.
REQ-014 SHALL have port done  out  1  frame fully delivered; held until next accepted start.

Function
REQ-015 SHALL implement FSM states IDLE, STREAM, FINISH.
REQ-016 IDLE -> STREAM on start; done cleared, issue address and output counters cleared to 0.
REQ-017 STREAM -> FINISH on handshake (out_valid & out_ready) of pixel IMG_W*IMG_H-1 (8063 at defaults).
REQ-018 FINISH -> STREAM on start; otherwise stays in FINISH with done=1.
REQ-019 start while in STREAM SHALL be ignored.
REQ-020 Reads SHALL be issued in raster order, addresses 0..IMG_W*IMG_H-1, each exactly once; mem_addr SHALL be held at its last value when mem_rd=0.
REQ-021 SHALL buffer returned data in a 2-entry FIFO; a read SHALL be issued in a cycle only if (FIFO count + reads in flight - pop this cycle) < 2 and addresses remain.
REQ-022 out_valid SHALL equal FIFO not empty; out_data/out_sof/out_eol come from the FIFO head and SHALL be stable while out_valid & !out_ready.
REQ-023 Latency: start sampled in cycle T -> mem_rd=1, mem_addr=0 in T+1 -> out_valid=1 with pixel 0 in T+3.
REQ-024 With out_ready held high, SHALL sustain one pixel per cycle with no bubbles after the first.
REQ-025 Simultaneous FIFO push and pop SHALL keep count unchanged; push into a full FIFO SHALL never occur (guaranteed by REQ-021).
REQ-026 out_sof/out_eol SHALL be derived from the address carried with each FIFO entry (address==0; address[6:0]==IMG_W-1 at defaults); column counter wraps IMG_W-1 -> 0.
REQ-027 busy and done SHALL never be high simultaneously.

Reset
REQ-028 On rst: state=IDLE, mem_rd=0, mem_addr=0, out_valid=0, out_data=0, out_sof=0, out_eol=0, busy=0, done=0, FIFO empty, in-flight flag cleared.
REQ-029 rst asserted mid-frame SHALL abort; mem_data returning for a pre-reset read SHALL be discarded.

Structure
REQ-030 SHALL place IMG_W, IMG_H, ADDR_W defaults and state encodings in the shared image package used by the interpolator.
REQ-031 The 2-entry FIFO SHALL be a sub-module named pix_fifo2 (data 8 bits + address tag).

Verification
REQ-032 Ramp memory (data=addr[7:0]), start, out_ready=1 -> 8064 pixels in order, first at T+3, 1/cycle, done at last+1 cycle.
REQ-033 out_ready toggling randomly -> identical sequence, no drops/duplicates, out_data stable while stalled.
REQ-034 Check markers -> out_sof only on pixel 0; out_eol on pixels 127, 255, ..., 8063 (63 pulses).
REQ-035 start pulsed mid-frame -> ignored, sequence unaffected; start in FINISH -> second full frame, done low during it.
REQ-036 rst asserted at pixel 4000 with read in flight -> all outputs at reset values next cycle; new start yields pixel 0 first.
REQ-037 out_ready=0 for 20 cycles after start -> exactly 2 reads issued, then mem_rd=0 until first pop.

Source files
------------

// File: rtl/frame_reader_pkg.sv
// Shared image package: frame geometry defaults, readout FSM encoding and
// the row-end helper used to mark the last pixel of each row.
package frame_reader_pkg;

    localparam int IMG_W_DEF  = 128;
    localparam int IMG_H_DEF  = 63;
    localparam int ADDR_W_DEF = 13;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FINISH = 2'd2
    } fr_state_e;

    function automatic logic is_row_end(input int addr, input int w);
        return (addr % w) == (w - 1);
    endfunction

endpackage

// File: rtl/frame_reader_pix_fifo2.sv
// Two-entry FIFO holding a returned pixel together with the address it was
// read from; the head is registered so it stays put while the consumer stalls.
module pix_fifo2 #(
    parameter int DW = 8,
    parameter int TW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic [TW-1:0] i_tag,
    input  logic          i_pop,
    output logic          o_empty,
    output logic [1:0]    o_count,
    output logic [DW-1:0] o_data,
    output logic [TW-1:0] o_tag
);

    logic [DW-1:0] r_data [2];
    logic [TW-1:0] r_tag  [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_data[r_wr_ptr] <= i_data;
                r_tag[r_wr_ptr]  <= i_tag;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;
    assign o_data  = r_data[r_rd_ptr];
    assign o_tag   = r_tag[r_rd_ptr];

endmodule

// File: rtl/frame_reader.sv
// Streams one IMG_W x IMG_H frame out of the result memory in raster order,
// one pixel per cycle when unstalled, with start/end-of-row markers.
module frame_reader
    import frame_reader_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              busy,
    output logic              done
);

    // state  | meaning
    // IDLE   | out of reset, waiting for the first start
    // STREAM | issuing reads and delivering pixels; start ignored
    // FINISH | frame delivered, done held until the next start

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(NPIX + 1);

    fr_state_e         r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_last_addr;
    logic [CNT_W-1:0]  r_rd_left;
    logic [CNT_W-1:0]  r_out_left;

    logic              w_issue;
    logic              w_pop;
    logic              w_empty;
    logic [1:0]        w_count;
    logic [2:0]        w_occ;
    logic [7:0]        w_head_data;
    logic [ADDR_W-1:0] w_head_addr;

    assign w_pop = !w_empty && out_ready;
    assign w_occ = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    // Left combinational so a pop frees its slot for a read in the same
    // cycle; registering it would cost a bubble every third pixel.
    assign w_issue = (r_state == ST_STREAM) && (r_rd_left != '0) && (w_occ < 3'd2);

    assign mem_rd   = w_issue;
    assign mem_addr = w_issue ? r_rd_addr : r_last_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_inflight  <= 1'b0;
            r_rd_addr   <= '0;
            r_last_addr <= '0;
            r_rd_left   <= '0;
            r_out_left  <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_last_addr <= r_rd_addr;
                r_rd_addr   <= r_rd_addr + ADDR_W'(1);
                r_rd_left   <= r_rd_left - CNT_W'(1);
            end
            case (r_state)
                ST_IDLE, ST_FINISH: begin
                    if (start) begin
                        r_state    <= ST_STREAM;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_rd_addr  <= '0;
                        r_rd_left  <= CNT_W'(NPIX);
                        r_out_left <= CNT_W'(NPIX);
                    end
                end
                ST_STREAM: begin
                    if (w_pop) begin
                        r_out_left <= r_out_left - CNT_W'(1);
                        if (r_out_left == CNT_W'(1)) begin
                            r_state <= ST_FINISH;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // r_last_addr doubles as the tag of the read whose data returns this cycle.
    pix_fifo2 #(
        .DW (8),
        .TW (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  (mem_data),
        .i_tag   (r_last_addr),
        .i_pop   (w_pop),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_data  (w_head_data),
        .o_tag   (w_head_addr)
    );

    assign out_valid = !w_empty;
    assign out_data  = w_head_data;
    assign out_sof   = !w_empty && (w_head_addr == '0);
    assign out_eol   = !w_empty && is_row_end(int'(w_head_addr), IMG_W);
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_frame_reader.sv
// Scoreboard bench for frame_reader: frames of random or ramp memory content,
// random back-pressure, ignored starts, mid-frame reset and restart.
module tb_frame_reader;

    localparam int IMG_W  = 128;
    localparam int IMG_H  = 63;
    localparam int ADDR_W = 13;
    localparam int NPIX   = IMG_W * IMG_H;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eol;
    } pix_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_sof;
    logic              out_eol;
    logic              busy;
    logic              done;

    logic [7:0] ram [NPIX];
    pix_t       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         frame_id = 0;
    int         n_pix = 0;

    frame_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data for the address strobed in cycle c appears in c+1.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill_ram(input bit ramp);
        for (int i = 0; i < NPIX; i++) ram[i] = ramp ? 8'(i) : 8'($urandom);
    endtask

    // Enqueue the whole expected frame, then pulse start; returns in cycle T+1.
    task automatic start_frame();
        pix_t p;
        exp_q.delete();
        for (int i = 0; i < NPIX; i++) begin
            p.d   = ram[i];
            p.sof = (i == 0);
            p.eol = ((i % IMG_W) == IMG_W - 1);
            exp_q.push_back(p);
        end
        frame_id++;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Monitor: read order, pixel scoreboard, stall stability, end-of-frame flags.
    initial begin
        int   mon_id = 0;
        int   exp_rd = 0;
        int   n_sof = 0;
        int   n_eol = 0;
        bit   have_hold = 0;
        bit   chk_done = 0;
        pix_t held;
        pix_t got;
        pix_t e;
        forever begin
            @(negedge clk);
            if (mon_id != frame_id) begin
                mon_id = frame_id; exp_rd = 0; n_sof = 0; n_eol = 0;
                n_pix = 0; have_hold = 0; chk_done = 0;
            end
            if (rst) begin
                have_hold = 0; chk_done = 0;
            end else begin
                got = '{d: out_data, sof: out_sof, eol: out_eol};
                check("busy_done_excl", 64'(busy & done), 64'd0);
                if (chk_done) begin
                    chk_done = 0;
                    check("done_after_last", 64'({done, busy}), 64'b10);
                    check("sof_count", 64'(n_sof), 64'd1);
                    check("eol_count", 64'(n_eol), 64'(IMG_H));
                end
                if (have_hold && out_valid) check("stall_stable", 64'(got), 64'(held));
                have_hold = out_valid && !out_ready;
                held = got;
                if (mem_rd) begin
                    check("rd_addr", 64'(mem_addr), 64'(exp_rd));
                    exp_rd++;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pixel", 64'(got), 64'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", 64'(got), 64'(e));
                    end
                    n_pix++;
                    if (out_sof) n_sof++;
                    if (out_eol) n_eol++;
                    if (n_pix == NPIX) chk_done = 1;
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrd;
        int cyc;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        fill_ram(1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("reset_vals", 64'({mem_rd, mem_addr, out_valid, out_data, out_sof, out_eol, busy, done}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Frame A: ramp, always ready, cycle-exact latency and throughput
        out_ready = 1'b1;
        start_frame();
        check("A_T1_rd", 64'({mem_rd, mem_addr, busy, done}), 64'({1'b1, 13'd0, 1'b1, 1'b0}));
        @(posedge clk); #1;
        check("A_T2_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("A_T3_pix0", 64'({out_valid, out_data, out_sof}), 64'({1'b1, 8'd0, 1'b1}));
        repeat (NPIX - 1) @(posedge clk);
        #1;
        check("A_last_no_bubble", 64'({out_valid, out_data, out_eol, done}), 64'({1'b1, 8'(NPIX - 1), 1'b1, 1'b0}));
        @(posedge clk); #1;
        check("A_done", 64'({done, busy}), 64'b10);
        repeat (3) @(posedge clk);
        #1;
        check("A_drained", 64'(exp_q.size()), 64'd0);
        check("A_done_held", 64'(done), 64'd1);

        // Frame B: start from FINISH, random stalls, stray starts mid-frame
        fill_ram(1'b0);
        start_frame();
        check("B_T1_done_low", 64'({done, busy}), 64'b01);
        cyc = 0;
        while (!done && cyc < 40000) begin
            out_ready = 1'($urandom_range(0, 1));
            start = (cyc == 50 || cyc == 3000);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; out_ready = 1'b1;
        check("B_done", 64'(done), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("B_drained", 64'(exp_q.size()), 64'd0);

        // Frame C: 20 cycles of back-pressure, then reset mid-frame
        fill_ram(1'b0);
        out_ready = 1'b0;
        start_frame();
        nrd = 0;
        for (int i = 0; i < 20; i++) begin
            nrd += int'(mem_rd);
            if (i == 19) check("C_rd_idle_stalled", 64'(mem_rd), 64'd0);
            @(posedge clk); #1;
        end
        check("C_reads_while_stalled", 64'(nrd), 64'd2);
        out_ready = 1'b1;
        #1;
        check("C_rd_on_first_pop", 64'({mem_rd, mem_addr}), 64'({1'b1, 13'd2}));
        cyc = 0;
        while (n_pix < 4000 && cyc < 10000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("C_reached_4000", 64'(n_pix), 64'd4000);
        check("C_read_in_flight", 64'(mem_rd), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("C_rst_async", 64'({mem_rd, mem_addr, out_valid, out_data, out_sof, out_eol, busy, done}), 64'd0);
        @(posedge clk); #1;
        check("C_rst_next", 64'({mem_rd, mem_addr, out_valid, out_data, out_sof, out_eol, busy, done}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("C_no_stale_data", 64'({out_valid, busy, done}), 64'd0);

        // Frame D: restart after abort, moderate random stalls
        fill_ram(1'b0);
        start_frame();
        check("D_T1_rd", 64'({mem_rd, mem_addr}), 64'({1'b1, 13'd0}));
        cyc = 0;
        while (!done && cyc < 40000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b1;
        check("D_done", 64'(done), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("D_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
